dma_engine: RTL and testbench

DMA_ENGINE -- requirements
Module: dma_engine

---
 rtl/dma_pkg.sv | 23 ++
 rtl/dma_if.sv | 25 ++
 rtl/dma_engine.sv | 160 ++++++++++++++++
 tb/tb_dma_engine.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the single-channel memory-to-memory DMA engine:
// FSM encoding, register offsets and CTRL bit positions.
package dma_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [1:0] REG_CTRL = 2'd0;
   localparam logic [1:0] REG_SRC  = 2'd1;
   localparam logic [1:0] REG_DST  = 2'd2;
   localparam logic [1:0] REG_LEN  = 2'd3;

   localparam int CTRL_START = 0;
   localparam int CTRL_IM    = 1;
   localparam int CTRL_BUSY  = 2;
   localparam int CTRL_DONE  = 3;
   localparam int CTRL_ABORT = 4;

endpackage

// File: rtl/dma_if.sv
// Register-slave port (south bridge) and bus-master port (north bridge) of the DMA.
// The "master" modport is the DMA engine's own view; "slave" is the surrounding system.
interface dma_if;
   logic [31:2] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;
   logic        M_Req;
   logic        M_Gnt;
   logic [31:0] M_Addr;
   logic [3:0]  M_WE;
   logic [31:0] M_WData;
   logic [31:0] M_RData;

   modport master (
      input  Addr, WE, Din, M_Gnt, M_RData,
      output Dout, IRQ, M_Req, M_Addr, M_WE, M_WData
   );

   modport slave (
      output Addr, WE, Din, M_Gnt, M_RData,
      input  Dout, IRQ, M_Req, M_Addr, M_WE, M_WData
   );
endinterface

// File: rtl/dma_engine.sv
// Word-at-a-time copy engine: read SRC, write DST, repeat LEN times.
// CPU-visible register file and the transfer FSM share this one body.
module dma_engine
   import dma_pkg::*;
#(
   parameter int LEN_W     = 16,
   parameter int MAX_BEATS = 0
) (
   input logic   clk,
   input logic   reset,
   dma_if.master bus
);

   state_e            state_q, state_d;
   logic [31:2]       src_q, src_d;
   logic [31:2]       dst_q, dst_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [31:0]       buf_q, buf_d;
   logic              im_q, im_d;
   logic              done_q, done_d;
   logic              irq_q, irq_d;

   logic busy, ctrl_wr, abort, start, beat;
   logic unused_addr;

   assign unused_addr = ^bus.Addr[31:4];

   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
      if (MAX_BEATS != 0 && l > LEN_W'(MAX_BEATS))
         return LEN_W'(MAX_BEATS);
      return l;
   endfunction

   assign busy    = (state_q == ST_READ) || (state_q == ST_WRITE);
   assign ctrl_wr = bus.WE && (bus.Addr[3:2] == REG_CTRL);
   assign abort   = ctrl_wr && bus.Din[CTRL_ABORT] && busy;
   // ABORT in the same write suppresses START
   assign start   = ctrl_wr && bus.Din[CTRL_START] && !bus.Din[CTRL_ABORT];
   assign beat    = busy && bus.M_Gnt;

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      buf_d   = buf_q;
      im_d    = im_q;
      done_d  = done_q;

      if (bus.WE && !busy) begin
         case (bus.Addr[3:2])
            REG_SRC: src_d = bus.Din[31:2];
            REG_DST: dst_d = bus.Din[31:2];
            REG_LEN: len_d = bus.Din[LEN_W-1:0];
            default: ;
         endcase
      end

      if (ctrl_wr) begin
         im_d   = bus.Din[CTRL_IM];
         done_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (len_q == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_READ;
                  len_d   = clamp_len(len_q);
               end
            end
         end
         ST_READ: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (beat) begin
               buf_d   = bus.M_RData;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            // an abort landing on a granted write leaves progress uncommitted
            if (abort) begin
               state_d = ST_IDLE;
            end else if (beat) begin
               src_d   = src_q + 30'd1;
               dst_d   = dst_q + 30'd1;
               len_d   = len_q - LEN_W'(1);
               state_d = (len_q == LEN_W'(1)) ? ST_DONE : ST_READ;
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      irq_d = done_d & im_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         buf_q   <= '0;
         im_q    <= 1'b0;
         done_q  <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         buf_q   <= buf_d;
         im_q    <= im_d;
         done_q  <= done_d;
         irq_q   <= irq_d;
      end
   end

   // Master outputs depend on registered state only, so a stalled beat holds steady.
   always_comb begin
      bus.M_Req   = 1'b0;
      bus.M_Addr  = '0;
      bus.M_WE    = '0;
      bus.M_WData = '0;
      case (state_q)
         ST_READ: begin
            bus.M_Req  = 1'b1;
            bus.M_Addr = {src_q, 2'b00};
         end
         ST_WRITE: begin
            bus.M_Req   = 1'b1;
            bus.M_Addr  = {dst_q, 2'b00};
            bus.M_WE    = 4'b1111;
            bus.M_WData = buf_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.Dout = '0;
      case (bus.Addr[3:2])
         REG_CTRL: bus.Dout = 32'({done_q, busy, im_q, 1'b0});
         REG_SRC:  bus.Dout = {src_q, 2'b00};
         REG_DST:  bus.Dout = {dst_q, 2'b00};
         REG_LEN:  bus.Dout = 32'(len_q);
         default:  bus.Dout = '0;
      endcase
   end

   assign bus.IRQ = irq_q;

endmodule

// File: tb/tb_dma_engine.sv
// Self-checking bench for dma_engine: expected bus beats come from a queue built
// from SRC/DST/LEN at job start; directed cases pin timing and corner cases.
module tb_dma_engine;
   import dma_pkg::*;

   localparam int MAXB = 8;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] data;
   } beat_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   dma_if bus();

   dma_engine #(.LEN_W(16), .MAX_BEATS(MAXB)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_fail = 0;
   logic        gnt_en = 1'b0;
   logic        gnt_rnd = 1'b0;
   int          gnt_pct = 100;
   logic [31:0] salt = 32'h0;
   logic [31:0] s0, d0;
   int          n_exp;
   int          wr_cnt;
   beat_t       exp_q[$];

   function automatic logic [31:0] pat(input logic [31:0] a, input logic [31:0] s);
      return {a[15:0], ~a[31:16]} ^ s;
   endfunction

   assign bus.M_Gnt   = gnt_en & gnt_rnd;
   assign bus.M_RData = pat(bus.M_Addr, salt);

   initial forever begin
      @(negedge clk);
      gnt_rnd = (int'($urandom_range(0, 99)) < gnt_pct);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   // Per-cycle bus compare, sampled well after the negedge stimulus and before posedge.
   initial begin
      logic        prev_stall;
      logic [31:0] prev_addr, prev_wd;
      logic [3:0]  prev_we;
      beat_t       e;
      prev_stall = 1'b0;
      prev_addr = '0; prev_wd = '0; prev_we = '0;
      forever begin
         @(negedge clk);
         #3;
         if (bus.M_Req) begin
            if (prev_stall) begin
               chk("hold_addr", bus.M_Addr, prev_addr);
               chk("hold_we", bus.M_WE, prev_we);
               chk("hold_wdata", bus.M_WData, prev_wd);
            end
            if (bus.M_Gnt) begin
               chk("beat_pending", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("beat_addr", bus.M_Addr, e.addr);
                  chk("beat_we", bus.M_WE, e.we);
                  if (e.we != 4'h0) begin
                     chk("beat_wdata", bus.M_WData, e.data);
                     wr_cnt++;
                  end
               end
            end
            prev_stall = !bus.M_Gnt;
            prev_addr = bus.M_Addr;
            prev_wd = bus.M_WData;
            prev_we = bus.M_WE;
         end else begin
            chk("idle_bus", {bus.M_WE, bus.M_Addr | bus.M_WData}, 0);
            prev_stall = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] r, input logic [31:0] d);
      bus.Addr = {28'($urandom), r};
      bus.WE = 1'b1;
      bus.Din = d;
      tick();
      bus.WE = 1'b0;
   endtask

   task automatic rd(input logic [1:0] r, output logic [31:0] d);
      bus.Addr = {28'($urandom), r};
      #1;
      d = bus.Dout;
   endtask

   // Program registers and build the expected beat list for the coming START.
   task automatic prog(input logic [31:0] src, input logic [31:0] dst, input int len);
      beat_t b;
      logic [31:0] a;
      wr(REG_SRC, src);
      wr(REG_DST, dst);
      wr(REG_LEN, 32'(len));
      s0 = {src[31:2], 2'b00};
      d0 = {dst[31:2], 2'b00};
      n_exp = (MAXB != 0 && len > MAXB) ? MAXB : len;
      salt = $urandom;
      wr_cnt = 0;
      exp_q.delete();
      for (int i = 0; i < n_exp; i++) begin
         a = s0 + 32'(4 * i);
         b.addr = a; b.we = 4'h0; b.data = pat(a, salt);
         exp_q.push_back(b);
         b.addr = d0 + 32'(4 * i); b.we = 4'hF;
         exp_q.push_back(b);
      end
   endtask

   task automatic wait_idle();
      logic [31:0] c;
      int t;
      t = 0;
      rd(REG_CTRL, c);
      while (c[CTRL_BUSY] && t < 3000) begin
         tick();
         rd(REG_CTRL, c);
         t++;
      end
      chk("idle_reached", 32'(c[CTRL_BUSY]), 0);
      tick();
      tick();
   endtask

   task automatic post_check(input logic aborted, input logic im);
      logic [31:0] c;
      rd(REG_SRC, c); chk("src_final", c, s0 + 32'(4 * wr_cnt)); tick();
      rd(REG_DST, c); chk("dst_final", c, d0 + 32'(4 * wr_cnt)); tick();
      rd(REG_LEN, c); chk("len_final", c, 32'(n_exp - wr_cnt)); tick();
      rd(REG_CTRL, c); chk("ctrl_final", c, 32'({!aborted, 1'b0, im, 1'b0}));
      chk("irq_final", 32'(bus.IRQ), 32'(!aborted & im));
      if (!aborted) chk("beats_left", exp_q.size(), 0);
      tick();
   endtask

   initial begin
      logic [31:0] c;
      logic [31:0] src, dst;
      logic im, ab;
      int len, dly;
      bus.Addr = '0; bus.WE = 1'b0; bus.Din = '0;
      repeat (3) tick();
      #1;
      chk("rst_req", 32'(bus.M_Req), 0);
      chk("rst_irq", 32'(bus.IRQ), 0);
      chk("rst_maddr", bus.M_Addr, 0);
      reset = 1'b0;
      tick();
      for (int r = 0; r < 4; r++) begin
         rd(2'(r), c);
         chk("rst_reg", c, 0);
         tick();
      end

      // 3-word copy with constant grant: fixed timing to DONE
      gnt_pct = 100; gnt_en = 1'b1;
      prog(32'h100, 32'h200, 3);
      wr(REG_CTRL, 32'h1);
      #1;
      chk("t1_req", 32'(bus.M_Req), 1);
      chk("t1_addr", bus.M_Addr, 32'h100);
      repeat (6) tick();
      rd(REG_CTRL, c); chk("t6_ctrl", c, 32'h0);
      tick();
      rd(REG_CTRL, c); chk("t7_ctrl", c, 32'h8);
      tick();
      rd(REG_SRC, c); chk("lit_src", c, 32'h10C); tick();
      rd(REG_DST, c); chk("lit_dst", c, 32'h20C); tick();
      chk("lit_beats", wr_cnt, 3);

      // IRQ rise after DONE, fall after CTRL write
      prog(32'h40, 32'h80, 1);
      wr(REG_CTRL, 32'h3);
      tick(); tick();
      #1 chk("irq_in_done", 32'(bus.IRQ), 0);
      tick();
      #1 chk("irq_rise", 32'(bus.IRQ), 1);
      wr(REG_CTRL, 32'h2);
      #1 chk("irq_fall", 32'(bus.IRQ), 0);
      rd(REG_CTRL, c); chk("irq_ctrl", c, 32'h2);
      tick();

      // Stalled write beat: outputs frozen, busy writes ignored, no beat lost
      prog(32'h500, 32'h300, 2);
      wr(REG_CTRL, 32'h1);
      tick();
      gnt_en = 1'b0;
      wr(REG_LEN, 32'h7);
      repeat (4) begin
         #1;
         chk("stall_addr", bus.M_Addr, 32'h300);
         chk("stall_we", 32'(bus.M_WE), 32'hF);
         chk("stall_wdata", bus.M_WData, pat(32'h500, salt));
         tick();
      end
      gnt_en = 1'b1;
      wait_idle();
      post_check(1'b0, 1'b0);
      chk("stall_beats", wr_cnt, 2);

      // Source address wrap
      gnt_pct = 60;
      prog(32'hFFFF_FFFC, 32'h2000, 2);
      wr(REG_CTRL, 32'h1);
      wait_idle();
      post_check(1'b0, 1'b0);
      rd(REG_SRC, c); chk("wrap_src", c, 32'h4); tick();

      // Abort after the first write beat
      gnt_pct = 100;
      prog(32'h100, 32'h200, 4);
      wr(REG_CTRL, 32'h1);
      tick(); tick();
      gnt_en = 1'b0;
      wr(REG_CTRL, 32'h10);
      gnt_en = 1'b1;
      exp_q.delete();
      rd(REG_CTRL, c); chk("abort_ctrl", c, 32'h0); tick();
      rd(REG_LEN, c); chk("abort_len", c, 32'h3); tick();
      rd(REG_SRC, c); chk("abort_src", c, 32'h104); tick();

      // Clamp to MAX_BEATS
      gnt_pct = 80;
      prog(32'h3000, 32'h4000, 11);
      wr(REG_CTRL, 32'h1);
      wait_idle();
      post_check(1'b0, 1'b0);
      chk("clamp_beats", wr_cnt, 8);

      // LEN==0 goes straight to DONE
      prog(32'h10, 32'h20, 0);
      wr(REG_CTRL, 32'h1);
      rd(REG_CTRL, c); chk("len0_done_state", c, 32'h0);
      tick();
      rd(REG_CTRL, c); chk("len0_done", c, 32'h8);
      tick();

      // START together with ABORT starts nothing
      prog(32'h10, 32'h20, 2);
      exp_q.delete();
      wr(REG_CTRL, 32'h11);
      rd(REG_CTRL, c); chk("startabort_ctrl", c, 32'h0);
      chk("startabort_req", 32'(bus.M_Req), 0);
      tick();

      // Asynchronous reset during a stalled READ
      prog(32'h700, 32'h800, 3);
      gnt_en = 1'b0;
      wr(REG_CTRL, 32'h3);
      tick();
      #2 reset = 1'b1;
      exp_q.delete();
      #1;
      chk("arst_req", 32'(bus.M_Req), 0);
      chk("arst_addr", bus.M_Addr, 0);
      chk("arst_we", 32'(bus.M_WE), 0);
      chk("arst_irq", 32'(bus.IRQ), 0);
      tick();
      reset = 1'b0;
      gnt_en = 1'b1;
      tick();
      rd(REG_SRC, c); chk("arst_src", c, 0); tick();
      rd(REG_LEN, c); chk("arst_len", c, 0); tick();
      rd(REG_CTRL, c); chk("arst_ctrl", c, 0); tick();

      // Randomized jobs, optionally aborted
      for (int j = 0; j < 24; j++) begin
         src = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         dst = $urandom;
         len = $urandom_range(0, 12);
         im = 1'($urandom);
         ab = ($urandom_range(0, 3) == 0);
         dly = $urandom_range(1, 12);
         gnt_pct = $urandom_range(30, 100);
         prog(src, dst, len);
         wr(REG_CTRL, 32'({im, 1'b1}));
         if (ab) begin
            repeat (dly) tick();
            rd(REG_CTRL, c);
            if (c[CTRL_BUSY]) begin
               gnt_en = 1'b0;
               wr(REG_CTRL, 32'({1'b1, 2'b00, im, 1'b0}));
               gnt_en = 1'b1;
               exp_q.delete();
            end else begin
               ab = 1'b0;
            end
         end
         wait_idle();
         post_check(ab, im);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
